bcd_conv_sched: RTL and testbench
=================================

# bcd_conv_sched

Scheduler that shares one iterative binary-to-BCD (double-dabble) engine between two requesters. The manual requester is a button-latched switch operand; the periodic requester is a free-running auto-increment counter. Requests are arbitrated round-robin, each conversion is sequenced over WIDTH cycles, and each result is written back to a per-requester BCD register. The block sits between the board switch/button inputs and the seven-segment/LED display decoders.

## Interface
- WIDTH, 8: binary operand width.
- DIGITS, 3: BCD digits per result; result width is 4*DIGITS.
- TICK_DIV, 50_000_000: clk cycles per auto tick; must be ≥ 2.
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- btn_n  in  1  raw button, active-low.
- switch  in  WIDTH  manual operand.
- latched  out  WIDTH  last captured switch value (drives LEDs).
- man_bcd  out  4*DIGITS  manual conversion result.
- man_hund_nz  out  1  man_bcd[11:8] != 0.
- auto_bin  out  WIDTH  current auto counter.
- auto_bcd  out  4*DIGITS  auto conversion result.
- busy  out  1  high in CONV and DONE.
- done  out  1  one-cycle pulse in the cycle after DONE (result just written).

## Operation
- Button: btn_n passes through two flops (b1 <= ~btn_n, b2 <= b1). press = b1 & ~b2 (rising edge of the pressed level).
- On a press cycle edge: latched <= switch and pend_m <= 1. A second press while pending overwrites latched and merges into a single request.
- Auto source: a down-counter reloads to TICK_DIV-1. On wrap: auto_bin <= auto_bin + 1 (modulo 2^WIDTH, 255→0) and pend_a <= 1.
- Arbiter, evaluated in IDLE:
  - One pending request: that source is granted.
  - Both pending: the source not equal to last_grant is granted.
  - last_grant resets to "auto", so manual wins the first tie.
- FSM states:
  - IDLE: no work pending; wait for a request.
  - CONV:
    - On entry from IDLE (grant edge E): shift <= operand (latched or auto_bin, sampled at E), bcd <= 0, cnt <= 0, src <= grant, last_grant <= grant, granted pending bit cleared.
    - A same-source request arriving at edge E keeps its pending bit set.
    - Each edge in CONV: every BCD digit ≥ 5 gets +3, then {bcd,shift} shifts left by 1; cnt++.
    - After WIDTH steps, go to DONE.
  - DONE: write bcd into man_bcd or auto_bcd according to src; go to IDLE.
- Operand changes after the grant edge do not affect the conversion in flight.
- Arithmetic: DIGITS*4 bits must hold 2^WIDTH-1, so the hundreds digit is ≤ 2 for WIDTH=8. No overflow is possible.
- Reset mid-operation: next state is IDLE, the in-flight result is discarded, and both pending bits are cleared.
- Reset value of every output is 0.

## Timing
- Manual press-pulse latency: btn_n low before edge k → b1=1 after k → press high in cycle k..k+1 → capture at edge k+1.
- Grant at edge E → CONV steps at edges E+1..E+WIDTH → DONE write at edge E+WIDTH+1 → new value visible after it, done pulse the same cycle.
- Earliest next grant is at edge E+WIDTH+2, i.e. a WIDTH+2 cycle service slot.
- Worst-case manual wait is 2*(WIDTH+2) cycles.
- busy rises after edge E and falls after edge E+WIDTH+1.
- Ticks and presses are accepted in every state; no request is lost, only merged.

## Configuration
- AUTO_SRC_EN defined: the tick counter, auto_bin, pend_a and round-robin are built as described.
- AUTO_SRC_EN undefined:
  - No tick counter is built; auto_bin and auto_bcd are tied to 0.
  - The arbiter always grants manual; last_grant is absent.
  - Manual timing is unchanged.

## Structure
- Shared package (bcd_pkg):
  - State enum IDLE/CONV/DONE.
  - Source encoding SRC_MAN=0, SRC_AUTO=1.
  - Constant BCD_W = 4*DIGITS.
  - Function for per-digit add-3 correction.
- Sub-module bin2bcd_step: combinational single double-dabble iteration, inputs {bcd, shift}, outputs the next {bcd, shift}.
- The FSM, arbiter, counters and result registers stay in bcd_conv_sched.

## Test plan
- Reset held 3 cycles → all outputs 0, busy 0.
- switch=8'hFF, press → latched=FF; WIDTH+2 cycles after the grant, man_bcd=12'h255, man_hund_nz=1, done pulses once.
- switch=8'd9 → man_bcd=12'h009, man_hund_nz=0; switch=0 → 12'h000.
- TICK_DIV=20, press coincident with a tick → manual converted first, auto next; repeat the tie → auto first.
- Auto run of 256 ticks → auto_bcd passes 12'h255, then auto_bin=0 and auto_bcd=12'h000.
- Reset asserted at CONV step 4 of a manual conversion → IDLE next cycle, man_bcd stays 0, no done pulse.
- Build without AUTO_SRC_EN → auto_bcd stays 0 for 1000 cycles; manual results are unchanged.

Source files
------------

// File: rtl/bcd_pkg.sv
// bcd_pkg: shared constants and helpers for the binary-to-BCD conversion scheduler.
//   - default operand width / digit count and the derived BCD result width
//   - FSM state encodings (IDLE/CONV/DONE) and requester source encodings
//   - add3_digit: per-digit double-dabble correction
package bcd_pkg;

    localparam int unsigned WIDTH_DFLT  = 8;
    localparam int unsigned DIGITS_DFLT = 3;
    localparam int unsigned BCD_W       = 4 * DIGITS_DFLT;

    // Scheduler states
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CONV = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Requester sources
    localparam logic SRC_MAN  = 1'b0;
    localparam logic SRC_AUTO = 1'b1;

    // A BCD digit of 5 or more gets +3 so the following left shift carries correctly.
    function automatic logic [3:0] add3_digit(input logic [3:0] d);
        return (d >= 4'd5) ? 4'(d + 4'd3) : d;
    endfunction

endpackage

// File: rtl/bcd_conv_sched_bin2bcd_step.sv
// bin2bcd_step: one combinational double-dabble iteration.
// Ports:
//   bcd_i   [4*DIGITS-1:0]  current BCD accumulator
//   shift_i [WIDTH-1:0]     remaining binary operand bits (MSB first)
//   bcd_o   [4*DIGITS-1:0]  accumulator after add-3 correction and left shift
//   shift_o [WIDTH-1:0]     operand shifted left by one
module bin2bcd_step
    import bcd_pkg::*;
#(
    parameter int unsigned WIDTH  = WIDTH_DFLT,
    parameter int unsigned DIGITS = DIGITS_DFLT
) (
    input  logic [4*DIGITS-1:0] bcd_i,
    input  logic [WIDTH-1:0]    shift_i,
    output logic [4*DIGITS-1:0] bcd_o,
    output logic [WIDTH-1:0]    shift_o
);

    localparam int unsigned BW = 4 * DIGITS;

    logic [BW-1:0] adj;

    // Correct every digit before the shift
    for (genvar g = 0; g < DIGITS; g++) begin : g_dig
        assign adj[4*g +: 4] = add3_digit(bcd_i[4*g +: 4]);
    end

    // {bcd, shift} shifted left by one as a single register pair
    assign bcd_o   = {adj[BW-2:0], shift_i[WIDTH-1]};
    assign shift_o = {shift_i[WIDTH-2:0], 1'b0};

endmodule

// File: rtl/bcd_conv_sched.sv
// bcd_conv_sched: shares one iterative binary-to-BCD engine between a button-latched
// switch operand (manual) and a free-running auto-increment counter (auto).
// Round-robin arbitration, WIDTH-cycle conversion, per-requester result registers.
// Build option: define AUTO_SRC_EN to build the auto tick source and round-robin;
// without it only the manual requester exists and auto outputs are tied to 0.
// Ports:
//   clk          single clock, rising edge
//   reset        synchronous active-high reset
//   btn_n        raw active-low button
//   switch       manual operand
//   latched      last captured switch value
//   man_bcd      manual conversion result
//   man_hund_nz  hundreds digit of man_bcd is non-zero
//   auto_bin     current auto counter value
//   auto_bcd     auto conversion result
//   busy         high while converting or writing back
//   done         one-cycle pulse after a result is written
module bcd_conv_sched
    import bcd_pkg::*;
#(
    parameter int unsigned WIDTH    = WIDTH_DFLT,
    parameter int unsigned DIGITS   = BCD_W / 4,
    parameter int unsigned TICK_DIV = 50_000_000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                btn_n,
    input  logic [WIDTH-1:0]    switch,
    output logic [WIDTH-1:0]    latched,
    output logic [4*DIGITS-1:0] man_bcd,
    output logic                man_hund_nz,
    output logic [WIDTH-1:0]    auto_bin,
    output logic [4*DIGITS-1:0] auto_bcd,
    output logic                busy,
    output logic                done
);

    localparam int unsigned BW    = 4 * DIGITS;
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    // Elaboration guard on the tick divider
    if (TICK_DIV < 2) begin : g_tick_div_chk
        $error("TICK_DIV must be at least 2");
    end

    logic               b1_q, b2_q, press_c;
    logic [WIDTH-1:0]   latched_q, latched_d;
    logic               pend_m_q, pend_m_d;
    logic [1:0]         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   shift_q, shift_d, step_shift;
    logic [BW-1:0]      bcd_q, bcd_d, step_bcd;
    logic               src_q, src_d;
    logic [BW-1:0]      man_bcd_q, man_bcd_d;
    logic               man_hund_nz_q, man_hund_nz_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               req_c, grant_src_c, take_c;
    logic [WIDTH-1:0]   auto_bin_c, operand_c;

    // Button: pressed-level rising edge after a two-flop sampler
    assign press_c = b1_q & ~b2_q;

    bin2bcd_step #(
        .WIDTH  (WIDTH),
        .DIGITS (DIGITS)
    ) u_step (
        .bcd_i   (bcd_q),
        .shift_i (shift_q),
        .bcd_o   (step_bcd),
        .shift_o (step_shift)
    );

`ifdef AUTO_SRC_EN
    localparam int unsigned TICK_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    logic [TICK_W-1:0]  tick_q, tick_d;
    logic               tick_c;
    logic [WIDTH-1:0]   auto_bin_q, auto_bin_d;
    logic [BW-1:0]      auto_bcd_q, auto_bcd_d;
    logic               pend_a_q, pend_a_d;
    logic               last_grant_q, last_grant_d;

    // Round-robin: on a tie the source that was not granted last wins
    always_comb begin
        req_c = pend_m_q | pend_a_q;
        if (pend_m_q && pend_a_q) begin
            grant_src_c = ~last_grant_q;
        end else if (pend_a_q) begin
            grant_src_c = SRC_AUTO;
        end else begin
            grant_src_c = SRC_MAN;
        end
    end

    assign auto_bin_c = auto_bin_q;

    // Tick divider, auto counter, auto request and auto result
    always_comb begin
        tick_c       = (tick_q == '0);
        tick_d       = tick_c ? TICK_W'(TICK_DIV - 1) : TICK_W'(tick_q - TICK_W'(1));
        auto_bin_d   = WIDTH'(auto_bin_q + WIDTH'(tick_c));
        pend_a_d     = (pend_a_q & ~(take_c & (grant_src_c == SRC_AUTO))) | tick_c;
        last_grant_d = take_c ? grant_src_c : last_grant_q;
        auto_bcd_d   = ((state_q == ST_DONE) && (src_q == SRC_AUTO)) ? bcd_q : auto_bcd_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tick_q       <= TICK_W'(TICK_DIV - 1);
            auto_bin_q   <= '0;
            auto_bcd_q   <= '0;
            pend_a_q     <= 1'b0;
            last_grant_q <= SRC_AUTO;
        end else begin
            tick_q       <= tick_d;
            auto_bin_q   <= auto_bin_d;
            auto_bcd_q   <= auto_bcd_d;
            pend_a_q     <= pend_a_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign auto_bin = auto_bin_q;
    assign auto_bcd = auto_bcd_q;
`else
    assign req_c       = pend_m_q;
    assign grant_src_c = SRC_MAN;
    assign auto_bin_c  = '0;
    assign auto_bin    = '0;
    assign auto_bcd    = '0;
`endif

    // Operand sampled at the grant edge
    assign operand_c = (grant_src_c == SRC_AUTO) ? auto_bin_c : latched_q;
    assign take_c    = (state_q == ST_IDLE) && req_c;

    // Next-state and datapath
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        shift_d       = shift_q;
        bcd_d         = bcd_q;
        src_d         = src_q;
        man_bcd_d     = man_bcd_q;
        man_hund_nz_d = man_hund_nz_q;
        done_d        = 1'b0;

        // A press on the grant edge keeps the manual request pending
        latched_d = press_c ? switch : latched_q;
        pend_m_d  = (pend_m_q & ~(take_c & (grant_src_c == SRC_MAN))) | press_c;

        case (state_q)
            ST_IDLE: begin
                if (req_c) begin
                    state_d = ST_CONV;
                    shift_d = operand_c;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    src_d   = grant_src_c;
                end
            end
            ST_CONV: begin
                bcd_d   = step_bcd;
                shift_d = step_shift;
                cnt_d   = CNT_W'(cnt_q + CNT_W'(1));
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
                if (src_q == SRC_MAN) begin
                    man_bcd_d     = bcd_q;
                    man_hund_nz_d = (bcd_q[11:8] != 4'd0);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            b1_q          <= 1'b0;
            b2_q          <= 1'b0;
            latched_q     <= '0;
            pend_m_q      <= 1'b0;
            cnt_q         <= '0;
            shift_q       <= '0;
            bcd_q         <= '0;
            src_q         <= SRC_MAN;
            man_bcd_q     <= '0;
            man_hund_nz_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            b1_q          <= ~btn_n;
            b2_q          <= b1_q;
            latched_q     <= latched_d;
            pend_m_q      <= pend_m_d;
            cnt_q         <= cnt_d;
            shift_q       <= shift_d;
            bcd_q         <= bcd_d;
            src_q         <= src_d;
            man_bcd_q     <= man_bcd_d;
            man_hund_nz_q <= man_hund_nz_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign latched     = latched_q;
    assign man_bcd     = man_bcd_q;
    assign man_hund_nz = man_hund_nz_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_bcd_conv_sched.sv
// tb_bcd_conv_sched: directed self-checking bench for bcd_conv_sched
// (WIDTH=8, DIGITS=3, TICK_DIV=20). Auto-source scenarios are built when
// AUTO_SRC_EN is defined; otherwise the tied-off auto outputs are checked.
module tb_bcd_conv_sched;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        btn_n = 1'b1;
    logic [7:0]  switch = 8'h00;
    logic [7:0]  latched;
    logic [11:0] man_bcd;
    logic        man_hund_nz;
    logic [7:0]  auto_bin;
    logic [11:0] auto_bcd;
    logic        busy;
    logic        done;

    int cyc = 0;
    int r   = 0;
    int n_vec = 0;
    int n_err = 0;

    bcd_conv_sched #(
        .WIDTH    (8),
        .DIGITS   (3),
        .TICK_DIV (20)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_n       (btn_n),
        .switch      (switch),
        .latched     (latched),
        .man_bcd     (man_bcd),
        .man_hund_nz (man_hund_nz),
        .auto_bin    (auto_bin),
        .auto_bcd    (auto_bcd),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    // Rising-edge index; sampled on the falling edge
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    // Return at the falling edge that follows rising edge e
    task automatic goto(input int e);
        while (cyc < e) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        btn_n = 1'b1;
        repeat (3) @(negedge clk);
        r     = cyc;
        reset = 1'b0;
    endtask

    // Press so that the switch value is captured at rising edge c
    task automatic press_at(input int c, input logic [7:0] v);
        goto(c - 2);
        btn_n  = 1'b0;
        switch = v;
        goto(c - 1);
        btn_n  = 1'b1;
    endtask

    function automatic logic [11:0] bcd_ref(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    initial begin
        // Reset state
        do_reset();
        chk("rst_latched",  32'(latched),     32'h0);
        chk("rst_man_bcd",  32'(man_bcd),     32'h0);
        chk("rst_hund_nz",  32'(man_hund_nz), 32'h0);
        chk("rst_auto_bin", 32'(auto_bin),    32'h0);
        chk("rst_auto_bcd", 32'(auto_bcd),    32'h0);
        chk("rst_busy",     32'(busy),        32'h0);
        chk("rst_done",     32'(done),        32'h0);

        // 0xFF: capture r+2, grant r+3, write r+12
        press_at(r + 2, 8'hFF);
        goto(r + 2);
        chk("ff_latched", 32'(latched), 32'hFF);
        chk("ff_busy_pre", 32'(busy), 32'h0);
        goto(r + 3);
        chk("ff_busy_grant", 32'(busy), 32'h1);
        goto(r + 4);
        switch = 8'h12;
        goto(r + 11);
        chk("ff_bcd_early", 32'(man_bcd), 32'h0);
        chk("ff_done_early", 32'(done), 32'h0);
        chk("ff_busy_done", 32'(busy), 32'h1);
        goto(r + 12);
        chk("ff_bcd", 32'(man_bcd), 32'h255);
        chk("ff_hund_nz", 32'(man_hund_nz), 32'h1);
        chk("ff_done", 32'(done), 32'h1);
        chk("ff_busy_end", 32'(busy), 32'h0);
        goto(r + 13);
        chk("ff_done_once", 32'(done), 32'h0);

        // 9 then 0
        do_reset();
        press_at(r + 2, 8'd9);
        goto(r + 12);
        chk("nine_bcd", 32'(man_bcd), 32'h009);
        chk("nine_hund_nz", 32'(man_hund_nz), 32'h0);
        press_at(r + 14, 8'd0);
        goto(r + 23);
        chk("zero_bcd_early", 32'(man_bcd), 32'h009);
        goto(r + 24);
        chk("zero_bcd", 32'(man_bcd), 32'h000);
        chk("zero_done", 32'(done), 32'h1);

        // Presses during a conversion merge into one request
        do_reset();
        press_at(r + 2, 8'd99);
        press_at(r + 5, 8'd11);
        press_at(r + 8, 8'd22);
        goto(r + 8);
        chk("merge_latched", 32'(latched), 32'd22);
        goto(r + 12);
        chk("merge_first", 32'(man_bcd), 32'h099);
        goto(r + 21);
        chk("merge_hold", 32'(man_bcd), 32'h099);
        goto(r + 22);
        chk("merge_second", 32'(man_bcd), 32'h022);
        chk("merge_done", 32'(done), 32'h1);
        goto(r + 23);
        chk("merge_done_off", 32'(done), 32'h0);

        // Reset at CONV step 4 (grant r+3, step 4 at r+7)
        do_reset();
        press_at(r + 2, 8'd77);
        goto(r + 6);
        chk("abort_busy_pre", 32'(busy), 32'h1);
        reset = 1'b1;
        goto(r + 7);
        reset = 1'b0;
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_latched", 32'(latched), 32'h0);
        for (int e = r + 7; e <= r + 20; e++) begin
            goto(e);
            chk("abort_no_done", 32'(done), 32'h0);
        end
        chk("abort_man_bcd", 32'(man_bcd), 32'h0);

`ifdef AUTO_SRC_EN
        // Auto source: tick m at r+20m, result written at r+20m+10
        do_reset();
        for (int m = 1; m <= 256; m++) begin
            goto(r + 20 * m + 10);
            chk("auto_bin", 32'(auto_bin), 32'(m % 256));
            chk("auto_bcd", 32'(auto_bcd), 32'(bcd_ref(m % 256)));
        end

        // Tie at r+20 with last grant = auto: manual first
        do_reset();
        press_at(r + 20, 8'd123);
        goto(r + 30);
        chk("tie1_man", 32'(man_bcd), 32'h123);
        chk("tie1_auto_wait", 32'(auto_bcd), 32'h000);
        goto(r + 40);
        chk("tie1_auto", 32'(auto_bcd), 32'h001);
        press_at(r + 50, 8'd45);
        goto(r + 50);
        chk("rr_auto2", 32'(auto_bcd), 32'h002);
        // Manual granted last, then tie at r+60: auto first
        press_at(r + 60, 8'd200);
        goto(r + 60);
        chk("rr_man45", 32'(man_bcd), 32'h045);
        goto(r + 70);
        chk("tie2_auto", 32'(auto_bcd), 32'h003);
        chk("tie2_man_wait", 32'(man_bcd), 32'h045);
        goto(r + 80);
        chk("tie2_man", 32'(man_bcd), 32'h200);
        chk("tie2_hund_nz", 32'(man_hund_nz), 32'h1);
`else
        // Tied-off auto source alongside a manual conversion
        do_reset();
        press_at(r + 2, 8'd128);
        for (int e = r + 3; e <= r + 1000; e++) begin
            goto(e);
            chk("noauto_bcd", 32'(auto_bcd), 32'h0);
            if (e % 100 == 0) chk("noauto_bin", 32'(auto_bin), 32'h0);
        end
        chk("noauto_man", 32'(man_bcd), 32'h128);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
